// File: rtl/alu_pkg.sv
// Shared opcode encodings for the ripple ALU bit cell.
package alu_pkg;

  localparam logic [1:0] ALU_AND = 2'd0;
  localparam logic [1:0] ALU_OR  = 2'd1;
  localparam logic [1:0] ALU_ADD = 2'd2;
  localparam logic [1:0] ALU_SLT = 2'd3;

  // SLT rides on a subtract, so the carry chain must stay live for it too.
  function automatic logic uses_adder(input logic [1:0] op);
    return (op == ALU_ADD) || (op == ALU_SLT);
  endfunction

endpackage

// File: rtl/my_1bit_alu_v3_full_adder_1b.sv
// Single-bit full adder used by the ALU bit cell.
module full_adder_1b (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/my_1bit_alu_v3.sv
// One-bit MIPS-style ALU slice: AND/OR/ADD/SLT with operand inversion,
// combinational outputs plus a registered copy of result and carry.
module my_1bit_alu_v3
  import alu_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       in1,
  input  logic       in2,
  input  logic       carryIn,
  input  logic       ainvert,
  input  logic       binvert,
  input  logic       less,
  input  logic [1:0] op,
  output logic       carryOut,
  output logic       result,
  output logic       set,
  output logic       overflow,
  output logic       result_q,
  output logic       carry_q
);

  logic a;
  logic b;
  logic sum;
  logic cfa;

  assign a = in1 ^ ainvert;
  assign b = in2 ^ binvert;

  full_adder_1b u_fa (
    .a    (a),
    .b    (b),
    .cin  (carryIn),
    .sum  (sum),
    .cout (cfa)
  );

  // less is only looked at under SLT, so an undriven less never leaks out.
  always_comb begin
    result = 1'b0;
    case (op)
      ALU_AND: result = a & b;
      ALU_OR:  result = a | b;
      ALU_ADD: result = sum;
      ALU_SLT: result = less;
      default: result = 1'b0;
    endcase
  end

  assign carryOut = uses_adder(op) ? cfa : 1'b0;
  assign overflow = uses_adder(op) ? (carryIn ^ cfa) : 1'b0;
  assign set      = sum;

  always_ff @(posedge clk) begin
    if (rst) begin
      result_q <= 1'b0;
      carry_q  <= 1'b0;
    end else begin
      result_q <= result;
      carry_q  <= carryOut;
    end
  end

endmodule

// File: tb/tb_my_1bit_alu_v3.sv
// Directed-vector bench for the one-bit ALU slice; one line per transaction.
module tb_my_1bit_alu_v3;
  import alu_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       in1, in2, carryIn, ainvert, binvert, less;
  logic [1:0] op;
  logic       carryOut, result, set, overflow, result_q, carry_q;

  int n_vec = 0;
  int n_bad = 0;

  my_1bit_alu_v3 dut (
    .clk      (clk),
    .rst      (rst),
    .in1      (in1),
    .in2      (in2),
    .carryIn  (carryIn),
    .ainvert  (ainvert),
    .binvert  (binvert),
    .less     (less),
    .op       (op),
    .carryOut (carryOut),
    .result   (result),
    .set      (set),
    .overflow (overflow),
    .result_q (result_q),
    .carry_q  (carry_q)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic got, input logic exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end else begin
      $display("ok   %s: %b", tag, got);
    end
  endtask

  // Sweeps {in1,in2} = 00..11; er/ec bit k is the expectation for {in1,in2}==k.
  task automatic sweep(input string tag, input logic ai, input logic bi, input logic ci,
                       input logic [1:0] o, input logic [3:0] er, input logic [3:0] ec);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      {in1, in2} = 2'(k);
      ainvert = ai; binvert = bi; carryIn = ci; op = o; less = 1'b1;
      #1;
      chk($sformatf("%s in=%02b result", tag, 2'(k)), result, er[k]);
      chk($sformatf("%s in=%02b carryOut", tag, 2'(k)), carryOut, ec[k]);
    end
  endtask

  initial begin
    rst = 1'b1; in1 = 0; in2 = 0; carryIn = 0; ainvert = 0; binvert = 0; less = 0; op = ALU_AND;

    // index order: bit0={in1,in2}=00 ... bit3=11
    sweep("AND",     1'b0, 1'b0, 1'b0, ALU_AND, 4'b1000, 4'b0000);
    sweep("NA&NB",   1'b1, 1'b1, 1'b1, ALU_AND, 4'b0001, 4'b0000);
    sweep("A|NB",    1'b0, 1'b1, 1'b1, ALU_OR,  4'b1101, 4'b0000);
    sweep("NA|NB",   1'b1, 1'b1, 1'b0, ALU_OR,  4'b0111, 4'b0000);
    sweep("ADD",     1'b0, 1'b0, 1'b0, ALU_ADD, 4'b0110, 4'b1000);
    sweep("SUB",     1'b0, 1'b1, 1'b1, ALU_ADD, 4'b0110, 4'b1101);

    // SLT passes less through and keeps the carry chain live
    @(negedge clk);
    in1 = 0; in2 = 0; ainvert = 0; binvert = 1; carryIn = 1; op = ALU_SLT; less = 1;
    #1;
    chk("SLT less=1 result", result, 1'b1);
    chk("SLT carryOut", carryOut, 1'b1);
    chk("SLT set", set, 1'b0);
    less = 0; #1;
    chk("SLT less=0 result", result, 1'b0);

    // set and overflow
    in1 = 1; in2 = 1; binvert = 0; carryIn = 0; op = ALU_ADD; #1;
    chk("ADD 1+1 set", set, 1'b0);
    chk("ADD 1+1 overflow", overflow, 1'b1);
    in1 = 1; in2 = 0; carryIn = 1; #1;
    chk("ADD 1+0+1 overflow", overflow, 1'b0);
    in1 = 1; in2 = 1; carryIn = 0; op = ALU_AND; #1;
    chk("AND 1&1 overflow gated", overflow, 1'b0);
    chk("AND set is raw sum", set, 1'b0);
    less = 1; in2 = 0; #1;
    chk("AND ignores less", result, 1'b0);

    // Registered copy: reset, then ADD 1+1
    in1 = 1; in2 = 1; carryIn = 0; op = ALU_ADD; rst = 1;
    @(posedge clk); #1;
    chk("rst result_q", result_q, 1'b0);
    chk("rst carry_q", carry_q, 1'b0);
    chk("rst leaves comb carryOut", carryOut, 1'b1);
    rst = 0;
    @(posedge clk); #1;
    chk("ADD 1+1 carry_q", carry_q, 1'b1);
    chk("ADD 1+1 result_q", result_q, 1'b0);
    in1 = 0; in2 = 1; #1;
    chk("latency carry_q holds", carry_q, 1'b1);
    @(posedge clk); #1;
    chk("ADD 0+1 result_q", result_q, 1'b1);
    chk("ADD 0+1 carry_q", carry_q, 1'b0);
    rst = 1;
    @(posedge clk); #1;
    chk("rst again result_q", result_q, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
